video_stream_arbiter: RTL

Frame-aware 2:1 Avalon-ST arbiter that feeds the video effects IP from either the camera sink (source 0) or the SD-card sink (source 1). Switching happens only on frame boundaries, so every forwarded frame is complete and starts with `startofpacket`. Source selection and pause come from the Avalon-MM register bank. Frame count and error status are reported back for software readout.

---
 rtl/video_pkg.sv | 25 ++
 rtl/video_st_out_reg.sv | 53 +++++
 rtl/video_stream_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and constants for the video stream arbiter and
//                the video effects IP (FSM states, pixel width, source ids).
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Pixel width for RGB565 video
    localparam int PIX_W = 16;

    // Source indices on the arbiter inputs
    localparam logic SRC_CAMERA = 1'b0;
    localparam logic SRC_SDCARD = 1'b1;

    // Frame-tracking states of the arbiter
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        STREAM = 2'd2
    } arb_state_t;

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_st_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : video_st_out_reg
//  Description : Single-register Avalon-ST output stage. When load is high the
//                register takes the offered beat, or empties if none is
//                offered. Data is held while the stage is not loading.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_st_out_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_data
);

    logic              r_valid;
    logic              r_sop;
    logic              r_eop;
    logic [DATA_W-1:0] r_data;

    // Output register: refill or empty on load, hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= in_valid;
            r_sop   <= in_valid & in_sop;
            r_eop   <= in_valid & in_eop;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign out_data  = r_data;

endmodule : video_st_out_reg
`default_nettype wire

// File: rtl/video_stream_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : video_stream_arbiter
//  Description : Frame-aware 2:1 Avalon-ST arbiter (camera / SD card) in front
//                of the video effects IP. Source changes and pause take effect
//                only on frame boundaries, so every forwarded frame starts
//                with startofpacket. Reports completed frames and protocol
//                errors.
//  Config      : VIDEO_ARB_DRAIN_EN - when defined, the unselected input (and
//                the selected input while idle) is held ready and its beats
//                are discarded; otherwise those inputs are backpressured.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_stream_arbiter
    import video_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_sel,
    input  logic              pause_req,
    input  logic              valid_in0,
    input  logic              startofpacket_in0,
    input  logic              endofpacket_in0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              ready_out0,
    input  logic              valid_in1,
    input  logic              startofpacket_in1,
    input  logic              endofpacket_in1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              ready_out1,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    output logic              active_src,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              frame_err
);

`ifdef VIDEO_ARB_DRAIN_EN
    // Parked inputs are drained so upstream never stalls
    localparam logic c_park_ready = 1'b1;
`else
    // Parked inputs are backpressured so no data is lost
    localparam logic c_park_ready = 1'b0;
`endif

    arb_state_t        r_state;
    logic              r_active_src;
    logic              r_busy;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_frame_err;

    logic              w_load;
    logic              w_sel_valid;
    logic              w_sel_sop;
    logic              w_sel_eop;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_ready;
    logic              w_acc;
    logic              w_fwd;

    // Output stage can take a beat when downstream drains it or it is empty
    assign w_load = ready_in | ~valid_out;

    // Route the selected source to the arbitration logic
    assign w_sel_valid = (r_active_src == SRC_SDCARD) ? valid_in1         : valid_in0;
    assign w_sel_sop   = (r_active_src == SRC_SDCARD) ? startofpacket_in1 : startofpacket_in0;
    assign w_sel_eop   = (r_active_src == SRC_SDCARD) ? endofpacket_in1   : endofpacket_in0;
    assign w_sel_data  = (r_active_src == SRC_SDCARD) ? data_in1          : data_in0;

    // Selected input follows the output stage, except while idle
    assign w_sel_ready = (r_state == IDLE) ? c_park_ready : w_load;

    assign ready_out0 = (r_active_src == SRC_CAMERA) ? w_sel_ready : c_park_ready;
    assign ready_out1 = (r_active_src == SRC_SDCARD) ? w_sel_ready : c_park_ready;

    // Beats drained while idle are not acceptances of the frame tracker
    assign w_acc = w_sel_valid & w_load & (r_state != IDLE);

    // While seeking only a start-of-frame beat is passed on
    assign w_fwd = w_acc & ((r_state == STREAM) | w_sel_sop);

    video_st_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .in_valid  (w_fwd),
        .in_sop    (w_sel_sop),
        .in_eop    (w_sel_eop),
        .in_data   (w_sel_data),
        .out_valid (valid_out),
        .out_sop   (startofpacket_out),
        .out_eop   (endofpacket_out),
        .out_data  (data_out)
    );

    // Frame tracker: source/pause latching, frame counting and error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_active_src <= SRC_CAMERA;
            r_frame_cnt  <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!pause_req) begin
                        r_state      <= SEEK;
                        r_active_src <= src_sel;
                    end
                end
                SEEK: begin
                    if (w_acc) begin
                        if (w_sel_sop && w_sel_eop) begin
                            // Single-beat frame: complete on arrival
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end else if (w_sel_sop) begin
                            r_state <= STREAM;
                            r_busy  <= 1'b1;
                        end else if (w_sel_eop) begin
                            // End of a frame whose start was never seen
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (w_acc) begin
                        if (w_sel_sop) begin
                            // New frame started before the old one ended
                            r_frame_err <= 1'b1;
                        end else if (w_sel_eop) begin
                            r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
                            r_active_src <= src_sel;
                            r_busy       <= 1'b0;
                            r_state      <= pause_req ? IDLE : SEEK;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign active_src = r_active_src;
    assign busy       = r_busy;
    assign frame_cnt  = r_frame_cnt;
    assign frame_err  = r_frame_err;

endmodule : video_stream_arbiter
`default_nettype wire
